// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   Sits between decode and execute. A per-register counter tracks
//   outstanding writes. A decoded instruction is held back while any of
//   these is true:
//     - a source it reads has a pending write
//     - its destination counter is saturated
//     - the total number of in-flight writes is at its cap
//   Decode valid/ready pass through to execute combinationally, gated by
//   that hazard.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   d_valid_i / d_ready_o       decode handshake
//   e_valid_o / E_ready_i       execute handshake
//   rs1_i, rs2_i, rd_i          operand / destination indices
//   use_rs1_i, use_rs2_i        instruction reads rs1 / rs2
//   wenReg_i                    instruction writes rd
//   wb_valid_i, wb_rd_i         writeback retiring one pending write
//   flush_i                     drop all pending state
//   busy_o                      any write pending
//   inflight_o                  total pending writes
//   stall_cnt_o                 cycles a valid instruction was held back
//   wb_err_o                    sticky: writeback with nothing pending
module issue_scoreboard #(
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned WB_BYPASS    = 1,
  parameter int unsigned REG_N        = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              d_valid_i,
  output logic                              d_ready_o,
  output logic                              e_valid_o,
  input  logic                              E_ready_i,
  input  logic [4:0]                        rs1_i,
  input  logic [4:0]                        rs2_i,
  input  logic [4:0]                        rd_i,
  input  logic                              use_rs1_i,
  input  logic                              use_rs2_i,
  input  logic                              wenReg_i,
  input  logic                              wb_valid_i,
  input  logic [4:0]                        wb_rd_i,
  input  logic                              flush_i,
  output logic                              busy_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
  output logic [31:0]                       stall_cnt_o,
  output logic                              wb_err_o
);

  localparam int unsigned     INF_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt [REG_N];
  logic [INF_W-1:0] r_inflight;
  logic [31:0]      r_stall_cnt;
  logic             r_wb_err;

  logic w_bypass;
  logic w_src1_haz;
  logic w_src2_haz;
  logic w_dst_haz;
  logic w_cap_haz;
  logic w_hazard;
  logic w_issue;
  logic w_issue_w;
  logic w_wb_dec;
  logic w_wb_bad;
  logic w_same;

  always_comb begin
    w_bypass   = (WB_BYPASS != 0) && wb_valid_i;
    // A writeback retiring the last pending write to a source releases it
    // in the same cycle.
    w_src1_haz = use_rs1_i && (rs1_i != '0) && (r_cnt[rs1_i] != '0) &&
                 !(w_bypass && (wb_rd_i == rs1_i) && (r_cnt[rs1_i] == CNT_ONE));
    w_src2_haz = use_rs2_i && (rs2_i != '0) && (r_cnt[rs2_i] != '0) &&
                 !(w_bypass && (wb_rd_i == rs2_i) && (r_cnt[rs2_i] == CNT_ONE));
    w_dst_haz  = wenReg_i && (rd_i != '0) && (r_cnt[rd_i] == CNT_MAX);
    w_cap_haz  = wenReg_i && (rd_i != '0) &&
                 (r_inflight == INF_W'(MAX_INFLIGHT)) &&
                 !(wb_valid_i && (wb_rd_i != '0));
    w_hazard   = w_src1_haz || w_src2_haz || w_dst_haz || w_cap_haz || flush_i;
    w_issue    = d_valid_i && E_ready_i && !w_hazard;
    w_issue_w  = w_issue && wenReg_i && (rd_i != '0);
    w_wb_dec   = wb_valid_i && (wb_rd_i != '0) && (r_cnt[wb_rd_i] != '0);
    w_wb_bad   = wb_valid_i && (wb_rd_i != '0) && (r_cnt[wb_rd_i] == '0);
    w_same     = w_issue_w && w_wb_dec && (wb_rd_i == rd_i);
  end

  // Handshake is held low during reset regardless of decode/execute.
  assign e_valid_o   = rst_n && d_valid_i && !w_hazard;
  assign d_ready_o   = rst_n && E_ready_i && !w_hazard;
  assign busy_o      = (r_inflight != '0);
  assign inflight_o  = r_inflight;
  assign stall_cnt_o = r_stall_cnt;
  assign wb_err_o    = r_wb_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_N; i++) r_cnt[i] <= '0;
      r_inflight  <= '0;
      r_stall_cnt <= '0;
      r_wb_err    <= 1'b0;
    end else if (flush_i) begin
      // Same-cycle writeback is discarded along with everything pending.
      for (int unsigned i = 0; i < REG_N; i++) r_cnt[i] <= '0;
      r_inflight <= '0;
    end else begin
      // An issue and a writeback hitting the same register cancel out.
      if (w_issue_w && !w_same) r_cnt[rd_i]    <= r_cnt[rd_i] + CNT_ONE;
      if (w_wb_dec && !w_same)  r_cnt[wb_rd_i] <= r_cnt[wb_rd_i] - CNT_ONE;
      case ({w_issue_w, w_wb_dec})
        2'b10:   r_inflight <= r_inflight + INF_W'(1);
        2'b01:   r_inflight <= r_inflight - INF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_wb_bad)              r_wb_err    <= 1'b1;
      if (d_valid_i && w_hazard) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard
//   Directed vectors with hand-computed expectations for issue_scoreboard
//   (default parameters: CNT_W=2, MAX_INFLIGHT=4, WB_BYPASS=1).
module tb_issue_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        d_valid_i;
  logic        d_ready_o;
  logic        e_valid_o;
  logic        E_ready_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [4:0]  rd_i;
  logic        use_rs1_i;
  logic        use_rs2_i;
  logic        wenReg_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic        busy_o;
  logic [2:0]  inflight_o;
  logic [31:0] stall_cnt_o;
  logic        wb_err_o;

  int unsigned n_checks;
  int unsigned n_fail;

  issue_scoreboard #(
    .CNT_W        (2),
    .MAX_INFLIGHT (4),
    .WB_BYPASS    (1),
    .REG_N        (32)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_valid_i   (d_valid_i),
    .d_ready_o   (d_ready_o),
    .e_valid_o   (e_valid_o),
    .E_ready_i   (E_ready_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .rd_i        (rd_i),
    .use_rs1_i   (use_rs1_i),
    .use_rs2_i   (use_rs2_i),
    .wenReg_i    (wenReg_i),
    .wb_valid_i  (wb_valid_i),
    .wb_rd_i     (wb_rd_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .inflight_o  (inflight_o),
    .stall_cnt_o (stall_cnt_o),
    .wb_err_o    (wb_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid_i  = 1'b0;
    E_ready_i  = 1'b1;
    rs1_i      = '0;
    rs2_i      = '0;
    rd_i       = '0;
    use_rs1_i  = 1'b0;
    use_rs2_i  = 1'b0;
    wenReg_i   = 1'b0;
    wb_valid_i = 1'b0;
    wb_rd_i    = '0;
    flush_i    = 1'b0;
  endtask

  task automatic instr(input logic [4:0] rd, input logic wen,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
    d_valid_i = 1'b1;
    rd_i      = rd;
    wenReg_i  = wen;
    rs1_i     = rs1;
    use_rs1_i = u1;
    rs2_i     = rs2;
    use_rs2_i = u2;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst_n     = 1'b0;
    d_valid_i = 1'b1;
    #1;
    check("rst_e_valid", {31'd0, e_valid_o}, 32'd0);
    check("rst_d_ready", {31'd0, d_ready_o}, 32'd0);
    step();
    step();
    check("rst_inflight", {29'd0, inflight_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_stall", stall_cnt_o, 32'd0);
    check("rst_wb_err", {31'd0, wb_err_o}, 32'd0);
    idle();
    rst_n = 1'b1;
    step();

    // ld x5, then add x6,x5,x1 stalls until wb x5 (bypassed)
    instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check("ld_e_valid", {31'd0, e_valid_o}, 32'd1);
    step();
    check("ld_inflight", {29'd0, inflight_o}, 32'd1);
    check("ld_busy", {31'd0, busy_o}, 32'd1);
    instr(5'd6, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1);
    #1;
    check("raw_e_valid", {31'd0, e_valid_o}, 32'd0);
    check("raw_d_ready", {31'd0, d_ready_o}, 32'd0);
    step();
    check("raw_stall1", stall_cnt_o, 32'd1);
    step();
    check("raw_stall2", stall_cnt_o, 32'd2);
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd5;
    #1;
    check("bypass_e_valid", {31'd0, e_valid_o}, 32'd1);
    check("bypass_d_ready", {31'd0, d_ready_o}, 32'd1);
    step();
    check("bypass_inflight", {29'd0, inflight_o}, 32'd1);
    check("bypass_stall", stall_cnt_o, 32'd2);
    idle();
    instr(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    check("x5_clear", {31'd0, e_valid_o}, 32'd1);
    idle();
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd6;
    step();
    check("x6_retired", {29'd0, inflight_o}, 32'd0);
    idle();

    // capacity: x1..x4 pending, x7 stalls, wb x2 lets it in
    for (int i = 1; i <= 4; i++) begin
      instr(5'(i), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step();
    end
    check("cap_inflight4", {29'd0, inflight_o}, 32'd4);
    instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check("cap_e_valid", {31'd0, e_valid_o}, 32'd0);
    step();
    check("cap_stall", stall_cnt_o, 32'd3);
    check("cap_inflight_hold", {29'd0, inflight_o}, 32'd4);
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd2;
    #1;
    check("cap_wb_e_valid", {31'd0, e_valid_o}, 32'd1);
    step();
    check("cap_wb_inflight", {29'd0, inflight_o}, 32'd4);

    // flush with x1,x3,x4,x7 pending; dependent read of x1 blocked in the
    // flush cycle and free right after
    idle();
    instr(5'd0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);
    flush_i = 1'b1;
    #1;
    check("flush_e_valid", {31'd0, e_valid_o}, 32'd0);
    step();
    check("flush_inflight", {29'd0, inflight_o}, 32'd0);
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_no_stall", stall_cnt_o, 32'd3);
    flush_i = 1'b0;
    #1;
    check("post_flush_issue", {31'd0, e_valid_o}, 32'd1);
    idle();

    // destination saturation on x9
    instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    step();
    step();
    check("dst_inflight3", {29'd0, inflight_o}, 32'd3);
    #1;
    check("dst_e_valid", {31'd0, e_valid_o}, 32'd0);
    step();
    check("dst_stall", stall_cnt_o, 32'd4);
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd9;
    #1;
    check("dst_wb_still_blocked", {31'd0, e_valid_o}, 32'd0);
    step();
    check("dst_wb_inflight", {29'd0, inflight_o}, 32'd2);
    check("dst_wb_stall", stall_cnt_o, 32'd5);
    #1;
    check("dst_same_e_valid", {31'd0, e_valid_o}, 32'd1);
    step();
    check("dst_same_inflight", {29'd0, inflight_o}, 32'd2);
    wb_valid_i = 1'b0;
    #1;
    check("dst_refill_e_valid", {31'd0, e_valid_o}, 32'd1);
    step();
    check("dst_refill_inflight", {29'd0, inflight_o}, 32'd3);
    #1;
    check("dst_full_again", {31'd0, e_valid_o}, 32'd0);
    step();
    check("dst_stall6", stall_cnt_o, 32'd6);
    idle();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("dst_flushed", {29'd0, inflight_o}, 32'd0);

    // x0 is never tracked
    instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    check("x0_e_valid", {31'd0, e_valid_o}, 32'd1);
    step();
    check("x0_inflight", {29'd0, inflight_o}, 32'd0);
    idle();
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd0;
    step();
    check("wb_x0_err", {31'd0, wb_err_o}, 32'd0);
    check("wb_x0_inflight", {29'd0, inflight_o}, 32'd0);

    // writeback with nothing pending is sticky
    wb_rd_i = 5'd10;
    step();
    check("wb_err_set", {31'd0, wb_err_o}, 32'd1);
    idle();
    step();
    check("wb_err_sticky", {31'd0, wb_err_o}, 32'd1);

    // async reset in the middle of a stall
    instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    instr(5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
    step();
    check("pre_rst_stall", stall_cnt_o, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_inflight", {29'd0, inflight_o}, 32'd0);
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_stall", stall_cnt_o, 32'd0);
    check("arst_wb_err", {31'd0, wb_err_o}, 32'd0);
    check("arst_e_valid", {31'd0, e_valid_o}, 32'd0);
    check("arst_d_ready", {31'd0, d_ready_o}, 32'd0);
    step();
    idle();
    rst_n = 1'b1;
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd5;
    step();
    check("post_rst_wb_err", {31'd0, wb_err_o}, 32'd1);
    check("post_rst_inflight", {29'd0, inflight_o}, 32'd0);
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
